// File: rtl/ldpc_codeword_deserializer.sv
// Bit-serial to 16-bit codeword deserializer with a small codeword FIFO feeding the LDPC decoder.
// Flags mid-codeword SOF (frame_err) and codewords dropped on a full FIFO (overflow).
module ldpc_codeword_deserializer #(
  parameter int CODEWORD_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ser_valid,
  input  logic                          ser_bit,
  input  logic                          ser_sof,
  input  logic                          dec_ready,
  input  logic                          err_clr,
  output logic [CODEWORD_WIDTH-1:0]     cw_out,
  output logic                          decode_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int BIT_W = $clog2(CODEWORD_WIDTH);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {HUNT, COLLECT} state_e;

  state_e                    state_q, state_d;
  logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
  logic [CODEWORD_WIDTH-1:0] sreg_q, sreg_d;
  logic                      push, frame_set;

  logic [CODEWORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      pop, full, push_ok, ovf_set;

  logic [CODEWORD_WIDTH-1:0] cw_q;
  logic                      de_q, ovf_q, ferr_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sreg_d    = sreg_q;
    push      = 1'b0;
    frame_set = 1'b0;
    if (ser_valid) begin
      case (state_q)
        HUNT: begin
          if (ser_sof) begin
            sreg_d    = '0;
            sreg_d[0] = ser_bit;
            bit_cnt_d = BIT_W'(1);
            state_d   = COLLECT;
          end
        end
        COLLECT: begin
          if (ser_sof) begin
            // Restart framing on the new SOF; the partial word is abandoned.
            frame_set = 1'b1;
            sreg_d    = '0;
            sreg_d[0] = ser_bit;
            bit_cnt_d = BIT_W'(1);
          end else begin
            sreg_d[bit_cnt_q] = ser_bit;
            if (bit_cnt_q == BIT_W'(CODEWORD_WIDTH - 1)) begin
              push      = 1'b1;
              bit_cnt_d = '0;
              state_d   = HUNT;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop     = (count_q != '0) && dec_ready;
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok = push && (!full || pop);
    ovf_set = push && !push_ok;
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HUNT;
      bit_cnt_q <= '0;
      sreg_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cw_q      <= '0;
      de_q      <= 1'b0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sreg_q    <= sreg_d;
      count_q   <= count_d;
      de_q      <= pop;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        cw_q     <= mem[rd_ptr_q];
      end
      ovf_q  <= ovf_set   | (ovf_q  & ~err_clr);
      ferr_q <= frame_set | (ferr_q & ~err_clr);
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= sreg_d;
  end

  assign cw_out     = cw_q;
  assign decode_en  = de_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ldpc_codeword_deserializer.sv
// Randomized bench for ldpc_codeword_deserializer, checked every cycle against a queue-based model.
module tb_ldpc_codeword_deserializer;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic          clk, rst, ser_valid, ser_bit, ser_sof, dec_ready, err_clr;
  logic [W-1:0]  cw_out;
  logic          decode_en, overflow, frame_err;
  logic [2:0]    fifo_count;

  ldpc_codeword_deserializer #(.CODEWORD_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ser_valid(ser_valid), .ser_bit(ser_bit), .ser_sof(ser_sof),
    .dec_ready(dec_ready), .err_clr(err_clr), .cw_out(cw_out), .decode_en(decode_en),
    .fifo_count(fifo_count), .overflow(overflow), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame in progress, bits gathered so far, and a queue of stored codewords.
  logic [W-1:0] q[$];
  bit           in_frame = 0;
  int           nbits    = 0;
  logic [W-1:0] word     = '0;
  logic [W-1:0] exp_cw   = '0;
  bit           exp_de   = 0;
  bit           exp_ovf  = 0;
  bit           exp_ferr = 0;
  int           pulses   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  task automatic model_edge();
    bit pop, ovf_set, ferr_set;
    if (rst) begin
      q.delete();
      in_frame = 0; nbits = 0; word = '0;
      exp_cw = '0; exp_de = 0; exp_ovf = 0; exp_ferr = 0;
      return;
    end
    ovf_set  = 0;
    ferr_set = 0;
    pop = (q.size() != 0) && dec_ready;
    exp_de = pop;
    if (pop) exp_cw = q.pop_front();
    if (ser_valid) begin
      if (ser_sof) begin
        if (in_frame) ferr_set = 1;
        word = '0;
        word[0] = ser_bit;
        nbits = 1;
        in_frame = 1;
      end else if (in_frame) begin
        word[nbits] = ser_bit;
        nbits++;
        if (nbits == W) begin
          in_frame = 0;
          nbits = 0;
          if (q.size() < DEPTH) q.push_back(word);
          else ovf_set = 1;
        end
      end
    end
    exp_ovf  = ovf_set  | (exp_ovf  & !err_clr);
    exp_ferr = ferr_set | (exp_ferr & !err_clr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (decode_en === 1'b1) pulses++;
    check("decode_en",  32'(decode_en),  32'(exp_de));
    check("cw_out",     32'(cw_out),     32'(exp_cw));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("overflow",   32'(overflow),   32'(exp_ovf));
    check("frame_err",  32'(frame_err),  32'(exp_ferr));
  endtask

  task automatic idle(input int n);
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send_word(input logic [W-1:0] w, input int nb, input int gap_pct,
                           input bit ready_on_last);
    for (int i = 0; i < nb; i++) begin
      while ($urandom_range(99) < gap_pct) begin
        ser_valid = 1'b0;
        ser_sof   = 1'($urandom);
        ser_bit   = 1'($urandom);
        cycle();
      end
      ser_valid = 1'b1;
      ser_sof   = (i == 0);
      ser_bit   = w[i];
      if (ready_on_last && i == W - 1) dec_ready = 1'b1;
      cycle();
    end
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
  endtask

  initial begin
    int p0;
    rst = 1'b1; ser_valid = 1'b0; ser_bit = 1'b0; ser_sof = 1'b0;
    dec_ready = 1'b0; err_clr = 1'b0;
    cycle();
    cycle();
    rst = 1'b0;
    dec_ready = 1'b1;
    idle(2);

    // Single codeword: pulse two cycles after the last bit.
    p0 = pulses;
    send_word(16'hA5C3, W, 0, 0);
    idle(4);
    check("single_pulses", 32'(pulses - p0), 32'd1);

    // Back-to-back words with random gaps.
    p0 = pulses;
    send_word(16'h1234, W, 30, 0);
    send_word(16'hFFFF, W, 30, 0);
    send_word(16'h0001, W, 30, 0);
    idle(6);
    check("b2b_pulses", 32'(pulses - p0), 32'd3);

    // SOF arriving at bit 7 of a word.
    send_word(16'h5A5A, 7, 0, 0);
    send_word(16'h8001, W, 0, 0);
    idle(4);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    idle(2);

    // Overflow: five words into a four-entry FIFO with the decoder stalled.
    dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_word(16'(16'h1100 + k), W, 10, 0);
    idle(2);
    p0 = pulses;
    dec_ready = 1'b1;
    idle(8);
    check("ovf_pulses", 32'(pulses - p0), 32'd4);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;

    // Full FIFO with push and pop landing on the same edge.
    dec_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_word(16'(16'h2200 + k), W, 0, 0);
    p0 = pulses;
    send_word(16'h22FF, W, 0, 1);
    idle(8);
    check("full_pushpop_pulses", 32'(pulses - p0), 32'd5);

    // Reset in the middle of assembly with entries queued.
    dec_ready = 1'b0;
    send_word(16'h3333, W, 0, 0);
    send_word(16'h4444, W, 0, 0);
    send_word(16'h5555, 9, 0, 0);
    rst = 1'b1;
    dec_ready = 1'b1;
    cycle();
    rst = 1'b0;
    p0 = pulses;
    idle(5);
    check("post_reset_pulses", 32'(pulses - p0), 32'd0);
    send_word(16'hBEEF, W, 0, 0);
    idle(4);

    // Random traffic: gaps, stray SOFs, stalls, flag clears and occasional reset.
    for (int c = 0; c < 600; c++) begin
      ser_valid = ($urandom_range(99) < 80);
      ser_sof   = ($urandom_range(99) < 6);
      ser_bit   = 1'($urandom);
      dec_ready = ($urandom_range(99) < 50);
      err_clr   = ($urandom_range(99) < 3);
      rst       = ($urandom_range(999) < 3);
      cycle();
    end
    rst = 1'b0; err_clr = 1'b0; dec_ready = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ldpc_codeword_deserializer.md
# ldpc_codeword_deserializer

Front-end stage upstream of the non-binary LDPC decoder. It assembles a bit-serial channel stream into 16-bit codewords and buffers them in a small FIFO. It then presents each codeword on `cw_out` with a one-cycle `decode_en` pulse, wired directly to the decoder's `codeword_in` / `decode_en`. It also flags framing errors and FIFO overflow.

## Interface
- `CODEWORD_WIDTH`, 16, codeword bits per frame; must match the decoder.
- `FIFO_DEPTH`, 4, codeword FIFO entries; power of two, ≥ 2.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ser_valid` in 1: `ser_bit` / `ser_sof` qualify this cycle.
- `ser_bit` in 1: channel bit, LSB (codeword bit 0) first.
- `ser_sof` in 1: marks bit 0 of a codeword; ignored when `ser_valid`=0.
- `dec_ready` in 1: downstream may accept a codeword this cycle.
- `err_clr` in 1: clears sticky `overflow` and `frame_err`.
- `cw_out` out `CODEWORD_WIDTH`: codeword to decoder; registered.
- `decode_en` out 1: one-cycle pulse; `cw_out` valid while high.
- `fifo_count` out clog2(`FIFO_DEPTH`)+1: entries currently stored.
- `overflow` out 1: sticky; a completed codeword was dropped because the FIFO was full.
- `frame_err` out 1: sticky; `ser_sof` arrived mid-codeword.

## Operation
- **Assembly FSM**
  - **HUNT**:
    - `ser_valid` & `ser_sof`: write `ser_bit` to shift-register bit 0, `bit_cnt`=1, go to COLLECT.
    - `ser_valid` & !`ser_sof`: bit discarded.
  - **COLLECT**:
    - `ser_valid` & !`ser_sof`: write `ser_bit` to bit `bit_cnt`, increment.
    - `ser_valid` & `ser_sof`: set `frame_err`, discard the partial word, restart with this bit as bit 0 (`bit_cnt`=1, stay in COLLECT).
    - When the bit at `bit_cnt`=`CODEWORD_WIDTH`-1 is accepted, the word is complete: issue a push request and return to HUNT with `bit_cnt`=0.
  - `ser_valid`=0 leaves state and counter unchanged (gaps allowed anywhere).
- **FIFO**:
  - Circular buffer with wrapping read/write pointers.
  - A push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` is set.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - There is no bypass: a push into an empty FIFO cannot be popped in the same cycle.
- **Output**:
  - A pop occurs when `fifo_count`≠0 & `dec_ready`=1.
  - On a pop, the head is registered into `cw_out` and `decode_en`=1 the following cycle. `decode_en`=0 otherwise.
  - `cw_out` holds its last value when no pop occurs.
  - At most one pop per cycle. Back-to-back pops give consecutive `decode_en` pulses.
- **Sticky flags**:
  - `err_clr` clears both flags.
  - If a set event and `err_clr` coincide, set wins.
- **Reset**: `cw_out`=0, `decode_en`=0, `fifo_count`=0, pointers 0, `overflow`=0, `frame_err`=0, FSM=HUNT, `bit_cnt`=0, shift register 0.
  - A partial word in assembly and all FIFO contents are discarded.
  - `rst` overrides every other input in the same cycle.

## Timing
- The last bit of a codeword is sampled at edge E. `fifo_count` increments after E.
- With an empty FIFO and `dec_ready`=1, the pop occurs at E+1. `decode_en`/`cw_out` are high/valid in the cycle after E+1 (2-cycle latency from the last-bit edge).
- The decoder samples `cw_out` on the edge where `decode_en`=1, so its registered `data_out` appears one further cycle later.
- Minimum codeword period is `CODEWORD_WIDTH` cycles. A `ser_sof` is accepted on the cycle immediately after the previous word's last bit.
- `dec_ready` low stalls pops only; assembly continues until the FIFO overflows.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- **Single codeword**: `ser_valid`=1 for 16 cycles, `ser_sof` on the first, bits of 0xA5C3 LSB-first, `dec_ready`=1 → one `decode_en` pulse 2 cycles after the last bit, `cw_out`=0xA5C3, `fifo_count` returns to 0, no flags set.
- **Back-to-back with gaps**: words 0x1234, 0xFFFF, 0x0001 with random `ser_valid` gaps → three pulses in order with matching `cw_out`, no extra pulses.
- **Mid-frame SOF**: `ser_sof` at bit 7 of a word, then 16 bits of 0x8001 → `frame_err`=1, only 0x8001 emitted. Pulse `err_clr` → `frame_err`=0.
- **Overflow**: `dec_ready`=0, send 5 words (with `FIFO_DEPTH`=4) → `fifo_count`=4, `overflow`=1. Raise `dec_ready` → exactly 4 consecutive pulses carrying words 1–4; word 5 is lost.
- **Full with simultaneous push/pop**: FIFO full, `dec_ready` rises on the cycle the 5th word completes → no overflow, `fifo_count` stays 4, then all 5 words are emitted.
- **Reset mid-operation**: assert `rst` after 9 bits of a word with 2 entries queued → all outputs 0 next cycle, no `decode_en` afterwards. A fresh word then decodes normally.
